frame_wr_gate: RTL

- Conditions the ISP output stream (vsync / data-enable / packed 32-bit RGBX pixel) before it enters the DDR3 write FIFO.
- Guarantees exactly SRC_H pixels per line and at most SRC_V lines per frame, so fixed-length DDR write bursts stay line-aligned.
- Drops the partial frame seen after reset or enable, and generates a clean one-cycle wr_load pulse at each frame start.
- Sits between isp_top and ddr3_ctrl_2port in the ISP clock domain.

---
 rtl/frame_wr_gate.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/frame_wr_gate.sv
// Purpose: conditions the ISP pixel stream ahead of the DDR write FIFO so every written
//          line is exactly SRC_H words and every frame holds at most SRC_V lines.
// Latency: 1 cycle from in_de/in_data to out_wren/out_data; no backpressure, input is never stalled.
//
// Ports:
//   pixel_clock, reset      - ISP clock, synchronous active-high reset
//   enable                  - level, sampled only at frame start
//   in_vs, in_de, in_data   - ISP frame sync (polarity VS_POL), pixel valid, RGBX pixel
//   out_load                - one-cycle pulse at each accepted frame start (DDR wr_load)
//   out_wren, out_data      - write FIFO enable / data (real pixels or PAD_DATA)
//   frame_done              - one-cycle pulse when the SRC_V-th line completes
//   err_long/short/overrun/frame - sticky error flags, cleared by err_clr
//   err_clr                 - one-cycle clear of all sticky errors (a same-cycle set wins)
//   line_cnt                - lines written in the current frame (saturates at SRC_V)
module frame_wr_gate #(
  parameter int unsigned SRC_H    = 800,
  parameter int unsigned SRC_V    = 480,
  parameter bit          VS_POL   = 1'b1,
  parameter logic [31:0] PAD_DATA = 32'h000000FF
) (
  input  logic        pixel_clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        in_vs,
  input  logic        in_de,
  input  logic [31:0] in_data,
  output logic        out_load,
  output logic        out_wren,
  output logic [31:0] out_data,
  output logic        frame_done,
  output logic        err_long,
  output logic        err_short,
  output logic        err_overrun,
  output logic        err_frame,
  input  logic        err_clr,
  output logic [10:0] line_cnt
);

  localparam int unsigned PW = $clog2(SRC_H + 1);
  localparam logic [PW-1:0] H_MAX = PW'(SRC_H);
  localparam logic [10:0]   V_MAX = 11'(SRC_V);

  typedef enum logic [1:0] {
    S_WAIT_VS = 2'd0,
    S_ACTIVE  = 2'd1,
    S_PAD     = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          vs_q;
  logic          de_q;
  logic          drop_q, drop_d;
  logic [PW-1:0] pix_cnt_q, pix_cnt_d;
  logic [10:0]   line_cnt_q, line_cnt_d;
  logic          out_load_q, out_load_d;
  logic          out_wren_q, out_wren_d;
  logic [31:0]   out_data_q, out_data_d;
  logic          frame_done_q, frame_done_d;
  logic          err_long_q, err_long_d;
  logic          err_short_q, err_short_d;
  logic          err_overrun_q, err_overrun_d;
  logic          err_frame_q, err_frame_d;

  logic          vs_act;
  logic          frame_start;
  logic          de_fall;
  logic [PW-1:0] pix_inc;
  logic [10:0]   line_next;
  logic          line_complete;
  logic          set_long, set_short, set_overrun, set_frame;

  assign vs_act      = (in_vs == VS_POL);
  assign frame_start = vs_act & ~vs_q;
  assign de_fall     = de_q & ~in_de;
  assign pix_inc     = pix_cnt_q + 1'b1;
  assign line_next   = (line_cnt_q >= V_MAX) ? V_MAX : line_cnt_q + 11'd1;

  always_comb begin
    state_d       = state_q;
    pix_cnt_d     = pix_cnt_q;
    line_cnt_d    = line_cnt_q;
    out_load_d    = 1'b0;
    out_wren_d    = 1'b0;
    out_data_d    = '0;
    frame_done_d  = 1'b0;
    line_complete = 1'b0;
    set_long      = 1'b0;
    set_short     = 1'b0;
    set_overrun   = 1'b0;
    set_frame     = 1'b0;
    // drop_q marks an input line that overlapped padding; it is discarded up to its falling edge.
    drop_d        = in_de ? drop_q : 1'b0;

    if (frame_start) begin
      // Frame start outranks everything, including a pixel on the same cycle.
      if ((state_q == S_ACTIVE || state_q == S_PAD) && line_cnt_q < V_MAX) begin
        set_frame = 1'b1;
      end
      pix_cnt_d  = '0;
      line_cnt_d = '0;
      drop_d     = 1'b0;
      if (enable) begin
        out_load_d = 1'b1;
        state_d    = S_ACTIVE;
      end else begin
        state_d = S_WAIT_VS;
      end
    end else begin
      case (state_q)
        S_ACTIVE: begin
          if (in_de) begin
            if (!drop_q) begin
              if (pix_cnt_q < H_MAX) begin
                out_wren_d = 1'b1;
                out_data_d = in_data;
                pix_cnt_d  = pix_inc;
              end else begin
                set_long = 1'b1;
              end
            end
          end else if (de_fall && !drop_q) begin
            if (pix_cnt_q >= H_MAX) begin
              line_complete = 1'b1;
            end else if (pix_cnt_q != '0) begin
              // First pad word goes out on the falling-edge cycle so padding
              // stays contiguous with the last real pixel.
              set_short  = 1'b1;
              out_wren_d = 1'b1;
              out_data_d = PAD_DATA;
              if (pix_inc == H_MAX) begin
                line_complete = 1'b1;
              end else begin
                pix_cnt_d = pix_inc;
                state_d   = S_PAD;
              end
            end
          end
        end

        S_PAD: begin
          if (in_de) begin
            set_overrun = 1'b1;
            drop_d      = 1'b1;
          end
          out_wren_d = 1'b1;
          out_data_d = PAD_DATA;
          if (pix_inc == H_MAX) begin
            line_complete = 1'b1;
          end else begin
            pix_cnt_d = pix_inc;
          end
        end

        default: ;
      endcase

      if (line_complete) begin
        pix_cnt_d  = '0;
        line_cnt_d = line_next;
        if (line_next == V_MAX) begin
          frame_done_d = 1'b1;
          state_d      = S_DONE;
        end else begin
          state_d = S_ACTIVE;
        end
      end
    end

    err_long_d    = set_long    | (err_long_q    & ~err_clr);
    err_short_d   = set_short   | (err_short_q   & ~err_clr);
    err_overrun_d = set_overrun | (err_overrun_q & ~err_clr);
    err_frame_d   = set_frame   | (err_frame_q   & ~err_clr);
  end

  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      state_q       <= S_WAIT_VS;
      // Track the vsync level through reset so a vsync already active at
      // release is not mistaken for a frame start.
      vs_q          <= vs_act;
      de_q          <= 1'b0;
      drop_q        <= 1'b0;
      pix_cnt_q     <= '0;
      line_cnt_q    <= '0;
      out_load_q    <= 1'b0;
      out_wren_q    <= 1'b0;
      out_data_q    <= '0;
      frame_done_q  <= 1'b0;
      err_long_q    <= 1'b0;
      err_short_q   <= 1'b0;
      err_overrun_q <= 1'b0;
      err_frame_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      vs_q          <= vs_act;
      de_q          <= in_de;
      drop_q        <= drop_d;
      pix_cnt_q     <= pix_cnt_d;
      line_cnt_q    <= line_cnt_d;
      out_load_q    <= out_load_d;
      out_wren_q    <= out_wren_d;
      out_data_q    <= out_data_d;
      frame_done_q  <= frame_done_d;
      err_long_q    <= err_long_d;
      err_short_q   <= err_short_d;
      err_overrun_q <= err_overrun_d;
      err_frame_q   <= err_frame_d;
    end
  end

  assign out_load    = out_load_q;
  assign out_wren    = out_wren_q;
  assign out_data    = out_data_q;
  assign frame_done  = frame_done_q;
  assign err_long    = err_long_q;
  assign err_short   = err_short_q;
  assign err_overrun = err_overrun_q;
  assign err_frame   = err_frame_q;
  assign line_cnt    = line_cnt_q;

endmodule
